// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types, load-target codes and memory-layout helpers for the FC layer sequencer
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_UNPACK,
        ST_START,
        ST_RUN,
        ST_WB,
        ST_DONE
    } fc_state_t;

    localparam logic [1:0] LD_INPUT  = 2'd0;
    localparam logic [1:0] LD_WEIGHT = 2'd1;
    localparam logic [1:0] LD_BIAS   = 2'd2;

    typedef logic [15:0] fc_word_t;

    // Row r of the weight matrix feeds output node r.
    function automatic int fc_weight_addr(input int base, input int n_in, input int row);
        return base + n_in + row * n_in;
    endfunction

    function automatic int fc_bias_addr(input int base, input int n_in, input int n_out);
        return base + n_in + n_in * n_out;
    endfunction

    function automatic int fc_out_addr(input int base, input int n_in, input int n_out);
        return fc_bias_addr(base, n_in, n_out) + n_out;
    endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// rtl/fc_layer_sequencer_if.sv - shared FC memory bus: row reads and single-word writes
interface fc_layer_sequencer_if
    import fc_pkg::*;
#(
    parameter int N_IN   = 120,
    parameter int ADDR_W = 14
);
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    fc_word_t            mem_wdata;
    logic                mem_ack;
    logic [N_IN*16-1:0]  mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/fc_row_unpacker.sv
// rtl/fc_row_unpacker.sv - latches one wide memory row and emits its 16-bit words one per cycle
module fc_row_unpacker
    import fc_pkg::*;
#(
    parameter int N_IN  = 120,
    parameter int CNT_W = 7
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [N_IN*16-1:0] i_row,
    input  logic [CNT_W-1:0]   i_len,
    output logic               o_valid,
    output fc_word_t           o_word,
    output logic [CNT_W-1:0]   o_cnt,
    output logic               o_last
);
    logic [N_IN*16-1:0] r_buf;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_len;
    logic               r_active;

    // The buffer shifts down so the current word always sits at the bottom.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf    <= '0;
            r_cnt    <= '0;
            r_len    <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_buf    <= i_row;
            r_cnt    <= '0;
            r_len    <= i_len;
            r_active <= (i_len != '0);
        end else if (r_active) begin
            r_buf <= r_buf >> 16;
            r_cnt <= r_cnt + 1'b1;
            if (o_last) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_valid = r_active;
    assign o_word  = r_buf[15:0];
    assign o_cnt   = r_cnt;
    assign o_last  = r_active && (r_cnt == r_len - 1'b1);
endmodule

// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - loads one FC layer from memory, runs it, writes its outputs back.
// Define FC_RELU_EN to clamp negative outputs to zero on writeback.
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int N_IN      = 120,
    parameter int N_OUT     = 84,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 14,
    parameter int IDX_W     = 14
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    fc_layer_sequencer_if.master bus,
    output logic                 o_ld_valid,
    output logic [1:0]           o_ld_sel,
    output logic [IDX_W-1:0]     o_ld_index,
    output fc_word_t             o_ld_data,
    output logic                 o_layer_start,
    input  logic                 i_layer_done,
    output logic [IDX_W-1:0]     o_out_idx,
    input  fc_word_t             i_out_data
);
    localparam int ROW_W = $clog2(N_OUT + 2);
    localparam int CNT_W = $clog2(N_IN + 1);
    localparam logic [ROW_W-1:0] BIAS_ROW = ROW_W'(N_OUT + 1);

    fc_state_t          r_state;
    logic [ROW_W-1:0]   r_row;
    logic               r_busy;
    logic               r_done;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [1:0]         r_ld_sel;
    logic [IDX_W-1:0]   r_ld_base;
    logic               r_layer_start;
    logic [IDX_W-1:0]   r_out_idx;

    logic               w_load;
    logic               w_bias_row;
    logic [1:0]         w_sel;
    logic [CNT_W-1:0]   w_len;
    logic [IDX_W-1:0]   w_base;
    logic [ADDR_W-1:0]  w_next_addr;
    logic               w_u_valid;
    fc_word_t           w_u_word;
    logic [CNT_W-1:0]   w_u_cnt;
    logic               w_u_last;
    fc_word_t           w_wb_data;

    assign w_load     = (r_state == ST_RD_REQ) && bus.mem_ack;
    assign w_bias_row = (r_row == BIAS_ROW);
    assign w_sel      = (r_row == '0) ? LD_INPUT : (w_bias_row ? LD_BIAS : LD_WEIGHT);
    assign w_len      = w_bias_row ? CNT_W'(N_OUT) : CNT_W'(N_IN);
    assign w_base     = (w_sel == LD_WEIGHT) ? IDX_W'((int'(r_row) - 1) * N_IN) : '0;
    // Row r_row+1 is weight row r_row unless the weights are exhausted.
    assign w_next_addr = (r_row == ROW_W'(N_OUT))
                       ? ADDR_W'(fc_bias_addr(BASE_ADDR, N_IN, N_OUT))
                       : ADDR_W'(fc_weight_addr(BASE_ADDR, N_IN, int'(r_row)));

    fc_row_unpacker #(.N_IN(N_IN), .CNT_W(CNT_W)) u_unpacker (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_row   (bus.mem_rdata),
        .i_len   (w_len),
        .o_valid (w_u_valid),
        .o_word  (w_u_word),
        .o_cnt   (w_u_cnt),
        .o_last  (w_u_last)
    );

`ifdef FC_RELU_EN
    assign w_wb_data = i_out_data[15] ? '0 : i_out_data;
`else
    assign w_wb_data = i_out_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_row         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_ld_sel      <= LD_INPUT;
            r_ld_base     <= '0;
            r_layer_start <= 1'b0;
            r_out_idx     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_row      <= '0;
                        r_busy     <= 1'b1;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= ADDR_W'(BASE_ADDR);
                        r_state    <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_ld_sel  <= w_sel;
                        r_ld_base <= w_base;
                        r_state   <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    if (w_u_last) begin
                        if (w_bias_row) begin
                            r_layer_start <= 1'b1;
                            r_state       <= ST_START;
                        end else begin
                            r_row      <= r_row + 1'b1;
                            r_mem_addr <= w_next_addr;
                            r_mem_req  <= 1'b1;
                            r_state    <= ST_RD_REQ;
                        end
                    end
                end
                ST_START: begin
                    r_layer_start <= 1'b0;
                    r_state       <= ST_RUN;
                end
                ST_RUN: begin
                    if (i_layer_done) begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= ADDR_W'(fc_out_addr(BASE_ADDR, N_IN, N_OUT));
                        r_out_idx  <= '0;
                        r_state    <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (r_out_idx == IDX_W'(N_OUT - 1)) begin
                        r_mem_we <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_out_idx  <= r_out_idx + 1'b1;
                        r_mem_addr <= r_mem_addr + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done     <= 1'b0;
                    r_out_idx  <= '0;
                    r_mem_addr <= '0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_we ? w_wb_data : '0;
    assign o_ld_valid    = w_u_valid;
    assign o_ld_sel      = r_ld_sel;
    assign o_ld_index    = w_u_valid ? (r_ld_base + IDX_W'(w_u_cnt)) : '0;
    assign o_ld_data     = w_u_valid ? w_u_word : '0;
    assign o_layer_start = r_layer_start;
    assign o_out_idx     = r_out_idx;
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb/tb_fc_layer_sequencer.sv - self-checking bench: vector table, random runs against a layout model, reset abort
module tb_fc_layer_sequencer;
    localparam int N_IN   = 4;
    localparam int N_OUT  = 3;
    localparam int BASE   = 0;
    localparam int ADDR_W = 14;
    localparam int IDX_W  = 14;
`ifdef FC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic layer_done;
    logic busy, done, ld_valid, layer_start;
    logic [1:0] ld_sel;
    logic [IDX_W-1:0] ld_index, out_idx;
    logic [15:0] ld_data, out_data;
    logic [15:0] outs [3];

    always #5 clk = ~clk;

    fc_layer_sequencer_if #(.N_IN(N_IN), .ADDR_W(ADDR_W)) bus ();

    fc_layer_sequencer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .BASE_ADDR(BASE), .ADDR_W(ADDR_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .reset(reset), .i_start(start), .o_busy(busy), .o_done(done),
        .bus(bus), .o_ld_valid(ld_valid), .o_ld_sel(ld_sel), .o_ld_index(ld_index),
        .o_ld_data(ld_data), .o_layer_start(layer_start), .i_layer_done(layer_done),
        .o_out_idx(out_idx), .i_out_data(out_data)
    );

    assign out_data = (out_idx < IDX_W'(N_OUT)) ? outs[out_idx[1:0]] : 16'h0000;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: returns a row after mem_lat extra cycles, optionally sprays stray acks while idle.
    int          mem_lat = 2;
    bit          junk_en = 1'b0;
    logic [15:0] mem_words [64];
    bit          addr_unstable, req_after_ack;

    initial begin
        int cnt;
        bit acked;
        bit prev_req;
        logic [ADDR_W-1:0] a0;
        cnt = 0; acked = 1'b0; prev_req = 1'b0; a0 = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req) begin
                if (!prev_req) a0 = bus.mem_addr;
                else if (bus.mem_addr != a0) addr_unstable = 1'b1;
                if (acked) req_after_ack = 1'b1;
                else if (cnt == mem_lat) begin
                    bus.mem_ack = 1'b1;
                    for (int w = 0; w < N_IN; w++)
                        bus.mem_rdata[w*16 +: 16] = mem_words[int'(bus.mem_addr) + w];
                    acked = 1'b1;
                end else cnt++;
            end else begin
                cnt = 0;
                acked = 1'b0;
                if (junk_en && $urandom_range(0, 3) == 0) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = {$urandom, $urandom};
                end
            end
            prev_req = bus.mem_req;
        end
    end

    logic [31:0] exp_ld[$], got_ld[$];
    int          exp_rd[$], got_rd[$];
    logic [31:0] got_wr[$];

    // Reference: walk the memory layout row by row and list every expected load write.
    function automatic void build_expected();
        exp_ld.delete();
        exp_rd.delete();
        for (int r = 0; r < N_OUT + 2; r++) begin
            int sel, a, len, idx;
            if (r == 0) begin
                sel = 0; a = BASE; len = N_IN;
            end else if (r <= N_OUT) begin
                sel = 1; a = BASE + N_IN + (r - 1) * N_IN; len = N_IN;
            end else begin
                sel = 2; a = BASE + N_IN + N_IN * N_OUT; len = N_OUT;
            end
            exp_rd.push_back(a);
            for (int w = 0; w < len; w++) begin
                idx = (sel == 1) ? (r - 1) * N_IN + w : w;
                exp_ld.push_back({2'(sel), 14'(idx), mem_words[a + w]});
            end
        end
    endfunction

    function automatic logic [15:0] relu_ref(input logic [15:0] v);
        return (RELU && $signed(v) < 0) ? 16'h0000 : v;
    endfunction

    function automatic logic any_output();
        return |{busy, done, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                 ld_valid, ld_sel, ld_index, ld_data, layer_start, out_idx};
    endfunction

    task automatic do_run(input int lat, input int llat, input bit p_start, input bit p_done,
                          input bit junk, input logic [2:0][15:0] ov, input logic [2:0][15:0] ew);
        int ls_cnt = 0, done_cnt = 0, overlap = 0, busy_bad = 0, cd = 0, tail = -1, mism;
        bit poked_s = 1'b0, poked_d = 1'b0, prev_req = 1'b0;
        for (int i = 0; i < 64; i++) mem_words[i] = 16'($urandom);
        for (int k = 0; k < 3; k++) outs[k] = ov[k];
        mem_lat = lat; junk_en = junk;
        addr_unstable = 1'b0; req_after_ack = 1'b0;
        got_ld.delete(); got_rd.delete(); got_wr.delete();
        build_expected();
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 3000 && tail != 0; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            layer_done = 1'b0;
            if (ld_valid) got_ld.push_back({ld_sel, ld_index, ld_data});
            if (bus.mem_we) got_wr.push_back({2'b00, bus.mem_addr, bus.mem_wdata});
            if (bus.mem_req && !prev_req) got_rd.push_back(int'(bus.mem_addr));
            prev_req = bus.mem_req;
            if (bus.mem_req && bus.mem_we) overlap++;
            if (cd > 0) begin
                cd--;
                if (cd == 0) layer_done = 1'b1;
            end
            if (p_start && ls_cnt > 0 && !poked_s && !layer_start) begin
                start = 1'b1; poked_s = 1'b1;
            end
            if (layer_start) begin
                ls_cnt++; cd = llat + 1;
            end
            if (p_done && ld_valid && !poked_d) begin
                layer_done = 1'b1; poked_d = 1'b1;
            end
            if (done_cnt == 0) begin
                if (done ? busy : !busy) busy_bad++;
            end
            if (done) begin
                done_cnt++;
                if (tail < 0) tail = 20;
            end
            if (tail > 0) tail--;
        end
        start = 1'b0; layer_done = 1'b0; junk_en = 1'b0;
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("layer_start_pulses", 64'(ls_cnt), 64'd1);
        check("ld_count", 64'(got_ld.size()), 64'(exp_ld.size()));
        mism = 0;
        for (int i = 0; i < got_ld.size() && i < exp_ld.size(); i++)
            if (got_ld[i] !== exp_ld[i]) mism++;
        check("ld_stream_mismatches", 64'(mism), 64'd0);
        check("read_count", 64'(got_rd.size()), 64'(N_OUT + 2));
        mism = 0;
        for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
            if (got_rd[i] != exp_rd[i]) mism++;
        check("read_addr_mismatches", 64'(mism), 64'd0);
        check("write_count", 64'(got_wr.size()), 64'(N_OUT));
        for (int k = 0; k < N_OUT && k < got_wr.size(); k++) begin
            check("wb_addr", 64'(got_wr[k][29:16]), 64'(BASE + N_IN + N_IN * N_OUT + N_OUT + k));
            check("wb_data", 64'(got_wr[k][15:0]), 64'(ew[k]));
        end
        check("req_we_overlap", 64'(overlap), 64'd0);
        check("busy_errors", 64'(busy_bad), 64'd0);
        check("req_addr_unstable", 64'(addr_unstable), 64'd0);
        check("req_after_ack", 64'(req_after_ack), 64'd0);
    endtask

    typedef struct {
        int lat;
        int llat;
        bit p_start;
        bit p_done;
        bit junk;
        logic [2:0][15:0] ov;
        logic [2:0][15:0] ew;
    } vec_t;

    function automatic vec_t mk(input int lat, input int llat, input bit ps, input bit pd, input bit jk,
                                input logic [15:0] o0, input logic [15:0] o1, input logic [15:0] o2,
                                input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        vec_t v;
        v.lat = lat; v.llat = llat; v.p_start = ps; v.p_done = pd; v.junk = jk;
        v.ov[0] = o0; v.ov[1] = o1; v.ov[2] = o2;
        v.ew[0] = e0; v.ew[1] = e1; v.ew[2] = e2;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        int seen, cnt;
        logic [2:0][15:0] ov, ew;

        vecs[0] = mk(2, 5, 0, 0, 0, 16'h0005, 16'hFFFE, 16'h7FFF,
                     16'h0005, RELU ? 16'h0000 : 16'hFFFE, 16'h7FFF);
        vecs[1] = mk(0, 1, 0, 1, 0, 16'h8000, 16'h0001, 16'h1234,
                     RELU ? 16'h0000 : 16'h8000, 16'h0001, 16'h1234);
        vecs[2] = mk(5, 3, 1, 0, 0, 16'h0000, 16'hFFFF, 16'h7FFE,
                     16'h0000, RELU ? 16'h0000 : 16'hFFFF, 16'h7FFE);
        vecs[3] = mk(1, 0, 1, 1, 1, 16'hA5A5, 16'h5A5A, 16'h0100,
                     RELU ? 16'h0000 : 16'hA5A5, 16'h5A5A, 16'h0100);

        reset = 1'b1; start = 1'b0; layer_done = 1'b0;
        for (int k = 0; k < 3; k++) outs[k] = 16'h0;
        for (int i = 0; i < 64; i++) mem_words[i] = 16'($urandom);
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", 64'(any_output()), 64'd0);
        reset = 1'b0;

        // Abort mid-UNPACK: reset held three cycles must silence the load path.
        mem_lat = 2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int c = 0; c < 50 && seen == 0; c++) begin
            @(negedge clk);
            if (ld_valid) seen = 1;
        end
        check("reached_unpack", 64'(seen), 64'd1);
        reset = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            cnt += int'(ld_valid) + int'(bus.mem_we);
        end
        check("reset_midrun_outputs_zero", 64'(any_output()), 64'd0);
        reset = 1'b0;
        repeat (15) begin
            @(negedge clk);
            cnt += int'(ld_valid) + int'(bus.mem_we) + int'(bus.mem_req) + int'(layer_start);
        end
        check("activity_after_abort", 64'(cnt), 64'd0);

        for (int i = 0; i < 4; i++) begin
            do_run(vecs[i].lat, vecs[i].llat, vecs[i].p_start, vecs[i].p_done, vecs[i].junk,
                   vecs[i].ov, vecs[i].ew);
            repeat (2) @(negedge clk);
        end

        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) begin
                ov[k] = 16'($urandom);
                ew[k] = relu_ref(ov[k]);
            end
            do_run($urandom_range(0, 5), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ov, ew);
            repeat (2) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fc_layer_sequencer.md
Name: fc_layer_sequencer

Overview:
Controller that feeds one fully-connected layer from the shared FC memory and stores the layer's results back into it.
- Fetches the input vector, the weight rows and the bias row from memory as wide rows.
- Unpacks each row into 16-bit load writes into the layer's operand storage.
- Pulses the layer start, waits for the layer to finish, then writes the N_OUT outputs back to memory.
- One instance per FC layer. The top level chains instances: start of layer 2 is driven from done of layer 1.

Parameters:
N_IN, 120, input nodes; also the memory row width in 16-bit words.
N_OUT, 84, output nodes; must satisfy N_OUT <= N_IN.
BASE_ADDR, 0, word address of this layer's input vector.
ADDR_W, 14, memory address width.
IDX_W, 14, load index width; must hold N_IN*N_OUT-1.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle request to run the layer
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when writeback completes
mem_req  out  1  row read request
mem_we  out  1  single-word write strobe
mem_addr  out  ADDR_W  word address for read or write
mem_wdata  out  16  write data
mem_ack  in  1  one-cycle pulse: mem_rdata valid
mem_rdata  in  N_IN*16  row data; word w is at bits [w*16 +: 16]
ld_valid  out  1  load-write strobe to the layer
ld_sel  out  2  load target: 0 input, 1 weight, 2 bias
ld_index  out  IDX_W  element index within the target
ld_data  out  16  element value
layer_start  out  1  one-cycle pulse to the layer
layer_done  in  1  layer finished; outputs are stable
out_idx  out  IDX_W  output node index requested from the layer
out_data  in  16  combinational read of outputs[out_idx]

Behaviour:
Interface: reset is reset, synchronous, active-high; clock is clk.

Reset:
- All outputs are 0 and the FSM is in IDLE.
- A reset asserted mid-operation aborts immediately. No further ld_valid or mem_we pulses are issued.

Memory layout (word addresses):
- Inputs at BASE_ADDR.
- Weight row r (output node r) at BASE_ADDR + N_IN + r*N_IN.
- Biases at BASE_ADDR + N_IN + N_IN*N_OUT.
- Outputs at the bias address + N_OUT.

FSM states and transitions:
- IDLE: start moves to RD_REQ with row counter = 0. start is ignored in every other state.
- RD_REQ: mem_req=1 with mem_addr held stable. When mem_ack arrives, the row is latched into the row buffer, mem_req drops next cycle, and the FSM moves to UNPACK.
- UNPACK: one ld_valid per cycle, word w = 0 up to len-1.
  - Row 0 (inputs): len=N_IN, sel=0, index=w.
  - Rows 1..N_OUT (weights): len=N_IN, sel=1, index=(row-1)*N_IN + w.
  - Row N_OUT+1 (biases): len=N_OUT, sel=2, index=w.
  - After the last word: go to RD_REQ for the next row, or to START if the bias row is done.
- START: layer_start=1 for exactly one cycle, then RUN.
- RUN: wait for layer_done. layer_done is only sampled in RUN and is ignored in all other states.
- WB: for k = 0 up to N_OUT-1, one word per cycle:
  - out_idx=k.
  - mem_we=1, mem_addr = output base + k, mem_wdata=out_data.
  - After the last word, go to DONE.
- DONE: done=1 for one cycle, busy=0, back to IDLE.

Handshake and timing rules:
- mem_ack outside RD_REQ is ignored.
- mem_req and mem_we are never high in the same cycle.
- Total rows read: N_OUT+2.
- Index arithmetic is unsigned, computed at IDX_W bits, with no wrap for legal parameters.
- Latency from start to done: sum over rows of (1 + memory latency + len) + 2 + layer time + N_OUT + 1 cycles.

Optional Feature:
FC_RELU_EN:
- Defined: during WB, mem_wdata = 0 when out_data[15]=1, otherwise out_data (ReLU on two's-complement values).
- Undefined: out_data is written unmodified.

Decomposition:
- Package fc_pkg: the FSM state enum; ld_sel codes LD_INPUT/LD_WEIGHT/LD_BIAS; the 16-bit word typedef; address-offset helper functions for the weight, bias and output bases.
- Sub-module fc_row_unpacker: N_IN*16-bit row buffer and word counter. It emits one word per cycle for a given length and flags the last word.

Test Plan (N_IN=4, N_OUT=3, memory model latency 2 unless stated):
1. Reset held for 3 cycles mid-UNPACK, then released -> all outputs 0, no ld_valid afterwards, next start runs a clean sequence.
2. Full run -> mem_addr sequence 0, 4, 8, 12, 16; 5 rows; 4+12+3 ld_valid pulses with weight indices 0..11; exactly one layer_start.
3. Memory model with latency 0 and with latency 5 -> identical ld stream; mem_req held stable until ack.
4. start pulsed during RUN -> ignored; spurious layer_done during UNPACK -> ignored, no early layer_start.
5. Writeback with out_data = {0x0005, 0xFFFE, 0x7FFF} -> writes to addresses 19, 20, 21, then done=1 for one cycle. Value at address 20 is 0xFFFE without FC_RELU_EN and 0x0000 with it.
